// File: rtl/plic_pkg.sv
// Shared types and constants for the PLIC source-side gateway logic.
// Pure declarations; no latency or backpressure of its own.
package plic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } gw_state_e;

  localparam int NumSrcDef = 32;
  localparam int SrcIdW    = $clog2(NumSrcDef);

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt source: pending FSM, registered rise detect and saturating edge counter.
// Level pend after 1 cycle, edge pend after 2; no backpressure, excess edges beyond the counter pulse ovf_o.
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int EdgeCntW = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o,
  output logic ovf_o
);

  localparam logic [EdgeCntW-1:0] CntMax = '1;

  gw_state_e           state_q, state_d;
  logic [EdgeCntW-1:0] cnt_q, cnt_d;
  logic                src_q;
  logic                rise_q;
  logic                ovf_d;
  logic                edge_hit;
  logic                cnt_full;

  // The rise pulse is registered so edge mode sees one more cycle than level mode.
  assign edge_hit = le_i & rise_q;
  assign cnt_full = (cnt_q == CntMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      rise_q  <= 1'b0;
      ip_o    <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_i;
      rise_q  <= src_i & ~src_q;
      ip_o    <= (state_d == PEND);
      ovf_o   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (le_i ? rise_q : src_i) state_d = PEND;
      end
      PEND: begin
        if (claim_i) state_d = SERV;
        if (edge_hit) begin
          if (cnt_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + 1'b1;
        end
      end
      SERV: begin
        if (complete_i) begin
          // A coincident edge is taken as the new request, so the count is left alone.
          if (edge_hit) begin
            state_d = PEND;
          end else if (le_i && (cnt_q != '0)) begin
            state_d = PEND;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (edge_hit) begin
          if (cnt_full) ovf_d = 1'b1;
          else          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!le_i) cnt_d = '0;
  end

endmodule

// File: rtl/plic_gateway.sv
// PLIC gateway: synchronizes raw source lines and runs one gateway cell per source; ID 0 is tied off.
// ip_o follows src_i after SyncStages+1 (level) or SyncStages+2 (edge) cycles; no backpressure.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int NumSrc     = 32,
  parameter int SyncStages = 2,
  parameter int EdgeCntW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] src_i,
  input  logic [NumSrc-1:0] le_i,
  input  logic [NumSrc-1:0] claim_i,
  input  logic [NumSrc-1:0] complete_i,
  output logic [NumSrc-1:0] ip_o,
  output logic [NumSrc-1:0] ovf_o
);

  logic [NumSrc-1:0] src_s;
  logic              unused_src0;

  if (SyncStages == 0) begin : g_nosync
    assign src_s = src_i;
  end else begin : g_sync
    logic [NumSrc-1:0] sync_q [SyncStages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= src_i;
        for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign src_s = sync_q[SyncStages-1];
  end

  // ID 0 means "no interrupt" and never produces a request.
  assign ip_o[0]     = 1'b0;
  assign ovf_o[0]    = 1'b0;
  assign unused_src0 = ^{src_s[0], le_i[0], claim_i[0], complete_i[0]};

  for (genvar k = 1; k < NumSrc; k++) begin : g_cell
    plic_gateway_cell #(
      .EdgeCntW (EdgeCntW)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .src_i      (src_s[k]),
      .le_i       (le_i[k]),
      .claim_i    (claim_i[k]),
      .complete_i (complete_i[k]),
      .ip_o       (ip_o[k]),
      .ovf_o      (ovf_o[k])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboard bench for plic_gateway: a cycle model and hand-computed directed checks feed queues
// that a separate monitor drains one cycle at a time.
module tb_plic_gateway;

  localparam int NS   = 32;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] src, le, claim, compl;
  logic [NS-1:0] ip, ovf;

  always #5 clk = ~clk;

  plic_gateway #(.NumSrc(NS), .SyncStages(2), .EdgeCntW(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src),
    .le_i       (le),
    .claim_i    (claim),
    .complete_i (compl),
    .ip_o       (ip),
    .ovf_o      (ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [NS-1:0] ip;
    logic [NS-1:0] ovf;
  } exp_t;

  typedef struct {
    int    cyc;
    int    idx;
    bit    is_ovf;
    bit    val;
    string name;
  } dir_t;

  exp_t mq[$];
  dir_t dq[$];

  task automatic chk_vec(string name, logic [NS-1:0] act, logic [NS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_bit(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference model, states: 0 idle, 1 pending, 2 in service.
  logic [NS-1:0] m_s1 = '0, m_s2 = '0, m_sq = '0, m_rq = '0;
  int   m_st  [NS];
  int   m_cnt [NS];
  exp_t m_e;
  bit   ein;

  always @(posedge clk) begin
    cyc++;
    m_e.ip  = '0;
    m_e.ovf = '0;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_sq = '0; m_rq = '0;
      for (int k = 0; k < NS; k++) begin
        m_st[k]  = 0;
        m_cnt[k] = 0;
      end
    end else begin
      for (int k = 1; k < NS; k++) begin
        ein = le[k] && m_rq[k];
        if (m_st[k] == 0) begin
          if (le[k] ? m_rq[k] : m_s2[k]) m_st[k] = 1;
        end else if (m_st[k] == 1) begin
          if (ein) begin
            if (m_cnt[k] == CMAX) m_e.ovf[k] = 1'b1;
            else m_cnt[k] = m_cnt[k] + 1;
          end
          if (claim[k]) m_st[k] = 2;
        end else begin
          if (compl[k] && ein) m_st[k] = 1;
          else if (compl[k] && le[k] && m_cnt[k] > 0) begin
            m_st[k]  = 1;
            m_cnt[k] = m_cnt[k] - 1;
          end else if (compl[k]) m_st[k] = 0;
          else if (ein) begin
            if (m_cnt[k] == CMAX) m_e.ovf[k] = 1'b1;
            else m_cnt[k] = m_cnt[k] + 1;
          end
        end
        if (!le[k]) m_cnt[k] = 0;
      end
      m_rq = m_s2 & ~m_sq;
      m_sq = m_s2;
      m_s2 = m_s1;
      m_s1 = src;
    end
    for (int k = 0; k < NS; k++) m_e.ip[k] = (m_st[k] == 1);
    mq.push_back(m_e);
  end

  // Monitor: compares the DUT every cycle against the model and any directed entries due now.
  exp_t mon_e;
  int   di;

  always @(posedge clk) begin
    #1;
    if (mq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL model_queue empty at cycle %0d", cyc);
    end else begin
      mon_e = mq.pop_front();
      chk_vec("ip_model", ip, mon_e.ip);
      chk_vec("ovf_model", ovf, mon_e.ovf);
    end
    di = 0;
    while (di < dq.size()) begin
      if (dq[di].cyc == cyc) begin
        chk_bit(dq[di].name, dq[di].is_ovf ? ovf[dq[di].idx] : ip[dq[di].idx], dq[di].val);
        dq.delete(di);
      end else if (dq[di].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s stale directed entry for cycle %0d", dq[di].name, dq[di].cyc);
        dq.delete(di);
      end else begin
        di++;
      end
    end
  end

  task automatic want(int dc, int idx, bit is_ovf, bit val, string name);
    dir_t d;
    d.cyc    = cyc + dc;
    d.idx    = idx;
    d.is_ovf = is_ovf;
    d.val    = val;
    d.name   = name;
    dq.push_back(d);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_claim(int k);
    claim[k] = 1'b1;
    tick(1);
    claim[k] = 1'b0;
  endtask

  task automatic do_complete(int k);
    compl[k] = 1'b1;
    tick(1);
    compl[k] = 1'b0;
  endtask

  task automatic rise(int k);
    src[k] = 1'b1;
    tick(2);
    src[k] = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    claim = '0;
    compl = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0;
    src   = '1;
    le    = '0;
    claim = '0;
    compl = '0;

    // Reset held with every line high.
    tick(1);
    for (int d = 1; d <= 3; d++) begin
      want(d, 1, 1'b0, 1'b0, "rst_ip1");
      want(d, 5, 1'b0, 1'b0, "rst_ip5");
      want(d, 31, 1'b0, 1'b0, "rst_ip31");
    end
    tick(4);
    src = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Async reset while source 3 is in service and source 6 pending.
    src[3] = 1'b1;
    src[6] = 1'b1;
    want(3, 3, 1'b0, 1'b1, "lvl3_pend");
    tick(4);
    do_claim(3);
    tick(1);
    #2 rst_n = 1'b0;
    #1 chk_vec("async_rst_ip", ip, '0);
    @(negedge clk);
    rst_n = 1'b1;
    want(2, 3, 1'b0, 1'b0, "rst_idle3_early");
    want(3, 3, 1'b0, 1'b1, "rst_idle3_repend");
    tick(5);
    src = '0;
    do_reset();

    // Level source 5: latency, latching, claim and complete.
    src[5] = 1'b1;
    want(2, 5, 1'b0, 1'b0, "lvl5_lat2");
    want(3, 5, 1'b0, 1'b1, "lvl5_lat3");
    tick(3);
    src[5] = 1'b0;
    want(4, 5, 1'b0, 1'b1, "lvl5_latched");
    tick(4);
    want(1, 5, 1'b0, 1'b0, "lvl5_claim");
    do_claim(5);
    tick(2);
    for (int d = 1; d <= 3; d++) want(d, 5, 1'b0, 1'b0, "lvl5_norepend");
    do_complete(5);
    tick(4);

    // Edge source 7: count three edges, overflow on the fourth, drain by rounds.
    le[7] = 1'b1;
    tick(1);
    want(3, 7, 1'b0, 1'b0, "edge7_lat3");
    want(4, 7, 1'b0, 1'b1, "edge7_lat4");
    rise(7);
    do_claim(7);
    for (int r = 0; r < 3; r++) begin
      want(4, 7, 1'b1, 1'b0, "edge7_noovf");
      rise(7);
    end
    want(4, 7, 1'b1, 1'b1, "edge7_ovf");
    want(5, 7, 1'b1, 1'b0, "edge7_ovf_pulse");
    want(4, 7, 1'b0, 1'b0, "edge7_serv_ip");
    rise(7);
    tick(2);
    for (int r = 0; r < 3; r++) begin
      want(1, 7, 1'b0, 1'b1, "edge7_repend");
      do_complete(7);
      tick(1);
      want(1, 7, 1'b0, 1'b0, "edge7_reclaim");
      do_claim(7);
      tick(1);
    end
    for (int d = 1; d <= 3; d++) want(d, 7, 1'b0, 1'b0, "edge7_final_idle");
    do_complete(7);
    tick(4);

    // Edge source 2: rise coincides with complete at count 0.
    le[2] = 1'b1;
    tick(1);
    rise(2);
    do_claim(2);
    tick(1);
    src[2] = 1'b1;
    tick(2);
    src[2] = 1'b0;
    tick(1);
    want(1, 2, 1'b0, 1'b1, "cmp_rise_pend");
    do_complete(2);
    tick(2);
    do_claim(2);
    tick(1);
    for (int d = 1; d <= 3; d++) want(d, 2, 1'b0, 1'b0, "cmp_rise_cnt0");
    do_complete(2);
    tick(4);

    // Stray claim/complete on level source 4, and traffic on reserved ID 0.
    want(1, 4, 1'b0, 1'b0, "stray_cmp_idle");
    want(2, 4, 1'b0, 1'b0, "stray_cmp_idle2");
    do_complete(4);
    src[4] = 1'b1;
    want(3, 4, 1'b0, 1'b1, "src4_pend");
    tick(3);
    src[4] = 1'b0;
    tick(1);
    do_claim(4);
    tick(1);
    want(1, 4, 1'b0, 1'b0, "stray_claim_serv");
    want(2, 4, 1'b0, 1'b0, "stray_claim_serv2");
    do_claim(4);
    tick(1);
    for (int d = 1; d <= 3; d++) want(d, 4, 1'b0, 1'b0, "src4_idle");
    do_complete(4);
    tick(3);
    le[0]    = 1'b1;
    claim[0] = 1'b1;
    compl[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      src[0] = ~src[0];
      want(1, 0, 1'b0, 1'b0, "id0_ip");
      want(1, 0, 1'b1, 1'b0, "id0_ovf");
      tick(1);
    end
    src[0]   = 1'b0;
    claim[0] = 1'b0;
    compl[0] = 1'b0;
    le[0]    = 1'b0;

    // Random traffic on sources 0..7 under a fixed trigger-mode mix.
    rst_n = 1'b0;
    le    = $urandom;
    src   = '0;
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      src[7:0] = src[7:0] ^ 8'($urandom & $urandom & $urandom);
      claim = '0;
      compl = '0;
      if ($urandom_range(0, 1) == 1) claim[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 2) == 0) compl[$urandom_range(0, 7)] = 1'b1;
      tick(1);
    end
    claim = '0;
    compl = '0;
    tick(3);

    if (dq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL directed_left %0d entries never checked", dq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
